// File: rtl/proc_row_scheduler_pkg.sv
// Shared types and constants for the 4-processor row scheduler.
package proc_row_scheduler_pkg;

  localparam int unsigned NUM_PROC = 4;
  localparam int unsigned MAX_SIZE = 8;

  // Mux bank selects: low bank feeds rows 0..3, high bank feeds rows 4..7.
  localparam logic BANK_LO = 1'b1;
  localparam logic BANK_HI = 1'b0;

  typedef logic [NUM_PROC-1:0] proc_mask_t;
  typedef logic [3:0]          size_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StRunA,
    StLoadB,
    StRunB,
    StDone,
    StErr
  } sched_state_t;

  // Processor i works on row base+i; it takes part only if that row exists.
  function automatic proc_mask_t row_mask(size_t n, size_t base);
    proc_mask_t m;
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      m[i] = (size_t'(i) + base) < n;
    end
    return m;
  endfunction

endpackage

// File: rtl/proc_row_scheduler_if.sv
// Control/handshake bundle between the front end and the row scheduler.
interface proc_row_scheduler_if;
  import proc_row_scheduler_pkg::*;

  logic       start;
  size_t      size;
  proc_mask_t proc_done;
  proc_mask_t cntrl_p;
  proc_mask_t proc_start;
  size_t      row_base;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, size, proc_done,
    input  cntrl_p, proc_start, row_base, busy, done, err
  );

  modport slave (
    input  start, size, proc_done,
    output cntrl_p, proc_start, row_base, busy, done, err
  );

endinterface

// File: rtl/proc_row_scheduler_sched_timeout.sv
// Loadable up-counter with clear/enable; flags when the count reaches Timeout.
module sched_timeout #(
  parameter int unsigned Timeout = 1023,
  parameter int unsigned Width   = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Clear wins over load, load wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == Width'(Timeout));

endmodule

// File: rtl/proc_row_scheduler.sv
// Sequences one or two 4-row passes over the processor array for an N x N multiply.
module proc_row_scheduler
  import proc_row_scheduler_pkg::*;
#(
  parameter int unsigned Timeout = 1023,
  parameter int unsigned ToW     = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  proc_row_scheduler_if.slave  bus
);

  sched_state_t state_q, state_d;
  size_t        n_q, n_d;
  proc_mask_t   mask_q, mask_d;
  proc_mask_t   en_a, en_b, en_cur, seen;
  proc_mask_t   cntrl_p_q, cntrl_p_d, proc_start_q, proc_start_d;
  size_t        row_base_q, row_base_d;
  logic         busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic         size_ok, pass_done, to_tc, in_run, in_load;

  assign size_ok = (bus.size != '0) && (bus.size <= size_t'(MAX_SIZE));
  // In IDLE the size is not latched yet, so pass A's first start mask uses the live input.
  assign en_a    = row_mask((state_q == StIdle) ? bus.size : n_q, '0);
  assign en_b    = row_mask(n_q, size_t'(NUM_PROC));
  assign en_cur  = (state_q == StRunB) ? en_b : en_a;
  assign in_run  = (state_q == StRunA) || (state_q == StRunB);
  assign in_load = (state_q == StLoadA) || (state_q == StLoadB);
  // Flags arriving this cycle count toward completion immediately.
  assign seen      = mask_q | (bus.proc_done & en_cur);
  assign pass_done = (seen == en_cur);

  sched_timeout #(
    .Timeout (Timeout),
    .Width   (ToW)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (in_load),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .en_i     (in_run),
    .tc_o     (to_tc)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion outranks timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = size_ok ? StLoadA : StErr;
      StLoadA: state_d = StRunA;
      StRunA: begin
        if (pass_done)  state_d = (n_q > size_t'(NUM_PROC)) ? StLoadB : StDone;
        else if (to_tc) state_d = StErr;
      end
      StLoadB: state_d = StRunB;
      StRunB: begin
        if (pass_done)  state_d = StDone;
        else if (to_tc) state_d = StErr;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next-state: driven from the state being entered so registered outputs line up.
  always_comb begin
    proc_start_d = '0;
    cntrl_p_d    = cntrl_p_q;
    row_base_d   = row_base_q;
    busy_d       = busy_q;
    done_d       = (state_q == StDone);
    err_d        = err_q;
    if ((state_q == StIdle) && bus.start) err_d = 1'b0;
    unique case (state_d)
      StLoadA: begin
        proc_start_d = en_a;
        cntrl_p_d    = {NUM_PROC{BANK_LO}};
        row_base_d   = '0;
        busy_d       = 1'b1;
      end
      StLoadB: begin
        proc_start_d = en_b;
        cntrl_p_d    = {NUM_PROC{BANK_HI}};
        row_base_d   = size_t'(NUM_PROC);
      end
      StDone: begin
        cntrl_p_d  = {NUM_PROC{BANK_LO}};
        row_base_d = '0;
      end
      StErr: begin
        cntrl_p_d  = {NUM_PROC{BANK_LO}};
        row_base_d = '0;
        busy_d     = 1'b0;
        err_d      = 1'b1;
      end
      default: ;
    endcase
    if (state_q == StDone) busy_d = 1'b0;
  end

  // Latched size and per-pass completion mask.
  always_comb begin
    n_d    = ((state_q == StIdle) && bus.start) ? bus.size : n_q;
    mask_d = in_load ? '0 : (in_run ? seen : mask_q);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q          <= '0;
      mask_q       <= '0;
      cntrl_p_q    <= {NUM_PROC{BANK_LO}};
      proc_start_q <= '0;
      row_base_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      n_q          <= n_d;
      mask_q       <= mask_d;
      cntrl_p_q    <= cntrl_p_d;
      proc_start_q <= proc_start_d;
      row_base_q   <= row_base_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.cntrl_p    = cntrl_p_q;
  assign bus.proc_start = proc_start_q;
  assign bus.row_base   = row_base_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_proc_row_scheduler.sv
// Randomized bench for proc_row_scheduler against a timeline model of each job.
module tb_proc_row_scheduler;
  import proc_row_scheduler_pkg::*;

  localparam int TimeoutCycles = 1023;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  proc_row_scheduler_if bus ();

  proc_row_scheduler #(
    .Timeout (TimeoutCycles),
    .ToW     (10)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int da[4];
  int db[4];
  int hang_pass = 0;  // 0: none, 1: a pass-A processor never finishes, 2: pass B
  int hang_idx  = 0;
  bit level_mode = 1'b0;
  bit err_model  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] en_mask(input int n, input int base);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (i + base) < n;
    return m;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " cntrl"}, bus.cntrl_p, 4'b1111);
    check_eq({tag, " ps"}, bus.proc_start, 4'b0000);
    check_eq({tag, " row"}, bus.row_base, 4'd0);
    check_eq({tag, " busy"}, bus.busy, 1'b0);
    check_eq({tag, " done"}, bus.done, 1'b0);
    check_eq({tag, " err"}, bus.err, 1'b0);
  endtask

  // Cycle 0 = the cycle in which start is presented; cycle c is sampled at its negedge.
  task automatic run_job(input int n, input int rst_at);
    logic [3:0] ea, eb, pd, exp_ps;
    bit valid, two, hang, in_b, aborted;
    int ka, kb, lp, ae, last, end_a, end_b;
    string t;
    valid = (n >= 1) && (n <= 8);
    two   = n > 4;
    hang  = valid && (hang_pass != 0);
    ea    = en_mask(n, 0);
    eb    = en_mask(n, 4);
    ka = 1;
    for (int i = 0; i < 4; i++)
      if (ea[i] && !(hang_pass == 1 && i == hang_idx) && (1 + da[i] > ka)) ka = 1 + da[i];
    kb = ka + 1;
    for (int i = 0; i < 4; i++)
      if (eb[i] && !(hang_pass == 2 && i == hang_idx) && (ka + 1 + db[i] > kb))
        kb = ka + 1 + db[i];
    lp = (hang_pass == 1) ? 1 : ka + 1;
    if (!valid) begin
      ae = 0; last = 2;
    end else if (hang) begin
      ae = lp + TimeoutCycles + 1; last = ae + 2;  // last RUN cycle, then ERR, then IDLE
    end else begin
      ae = two ? kb : ka; last = ae + 2;
    end
    end_a   = (hang_pass == 1) ? ae : ka;
    end_b   = (hang_pass == 2) ? ae : kb;
    aborted = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk_i);
      t = $sformatf("n%0d c%0d", n, c);
      exp_ps = 4'b0000;
      if (valid && c == 1) exp_ps = ea;
      if (valid && two && hang_pass != 1 && c == ka + 1) exp_ps = eb;
      check_eq({t, " ps"}, bus.proc_start, exp_ps);
      check_eq({t, " done"}, bus.done, valid && !hang && c == last);
      in_b = valid && two && hang_pass != 1 && c >= ka + 1;
      if (c == 0) begin
        check_eq({t, " busy"}, bus.busy, 1'b0);
        check_eq({t, " err"}, bus.err, err_model);
      end else if (valid) begin
        if (c <= ae) begin
          check_eq({t, " busy"}, bus.busy, 1'b1);
          check_eq({t, " err"}, bus.err, 1'b0);
          check_eq({t, " cntrl"}, bus.cntrl_p, in_b ? 4'b0000 : 4'b1111);
          check_eq({t, " row"}, bus.row_base, in_b ? 4'd4 : 4'd0);
        end
        if (c == last) begin
          check_eq({t, " busy"}, bus.busy, 1'b0);
          check_eq({t, " err"}, bus.err, hang);
          if (!hang) begin
            check_eq({t, " cntrl"}, bus.cntrl_p, 4'b1111);
            check_eq({t, " row"}, bus.row_base, 4'd0);
          end
        end
      end else begin
        check_eq({t, " busy"}, bus.busy, 1'b0);
        if (c == 2) check_eq({t, " err"}, bus.err, 1'b1);
      end
      // Drive this cycle's inputs: junk start/size while busy, processors from the timeline.
      bus.start = (c == 0) ? 1'b1 : ((valid && c <= ae) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.size  = (c == 0) ? 4'(n) : 4'($urandom_range(0, 15));
      pd = 4'($urandom_range(0, 15));
      if (valid && c >= 2 && c <= end_a) begin
        for (int i = 0; i < 4; i++)
          if (ea[i])
            pd[i] = (hang_pass == 1 && i == hang_idx) ? 1'b0 :
                    (level_mode ? (c >= 1 + da[i]) : (c == 1 + da[i]));
      end else if (valid && two && hang_pass != 1 && c >= ka + 2 && c <= end_b) begin
        for (int i = 0; i < 4; i++)
          if (eb[i])
            pd[i] = (hang_pass == 2 && i == hang_idx) ? 1'b0 :
                    (level_mode ? (c >= ka + 1 + db[i]) : (c == ka + 1 + db[i]));
      end
      bus.proc_done = pd;
      if (c == rst_at) begin
        #2 rst_ni = 1'b0;
        #1 check_reset_vals({t, " async rst"});
        @(negedge clk_i);
        check_reset_vals({t, " held rst"});
        bus.start     = 1'b0;
        bus.proc_done = 4'b0000;
        rst_ni        = 1'b1;
        err_model     = 1'b0;
        aborted       = 1'b1;
        break;
      end
    end
    if (!aborted) err_model = !(valid && !hang);
  endtask

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.size      = 4'd0;
    bus.proc_done = 4'b0000;
    @(negedge clk_i);
    check_reset_vals("por");
    rst_ni = 1'b1;

    // N=4, all processors done at cycle 5 -> done at cycle 7.
    da = '{4, 4, 4, 4};
    run_job(4, -1);
    // N=6, staggered flags over two passes.
    da = '{3, 5, 2, 7}; db = '{4, 2, 9, 9};
    run_job(6, -1);
    // N=3; bit 3 receives noise throughout.
    da = '{2, 6, 3, 1};
    run_job(3, -1);
    // Illegal sizes, then a legal one clears err.
    run_job(9, -1);
    run_job(0, -1);
    da = '{1, 3, 1, 1};
    run_job(2, -1);
    // N=5, processor 0 hangs in pass B.
    da = '{2, 2, 3, 4}; db = '{1, 1, 1, 1};
    hang_pass = 2; hang_idx = 0;
    run_job(5, -1);
    hang_pass = 0;
    // Reset in RUN_B (pass A done at 4, RUN_B spans 6..11), then a full N=8.
    da = '{3, 3, 3, 3}; db = '{6, 6, 6, 6};
    run_job(6, 7);
    da = '{2, 4, 1, 3}; db = '{5, 1, 2, 3};
    run_job(8, -1);

    for (int j = 0; j < 25; j++) begin
      n = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15))
                                      : $urandom_range(1, 8);
      for (int i = 0; i < 4; i++) begin
        da[i] = $urandom_range(1, 10);
        db[i] = $urandom_range(1, 10);
      end
      level_mode = 1'($urandom_range(0, 1));
      hang_pass  = 0;
      if (n >= 1 && n <= 8 && $urandom_range(0, 7) == 0) begin
        hang_pass = (n > 4 && $urandom_range(0, 1) == 1) ? 2 : 1;
        hang_idx  = (hang_pass == 1) ? $urandom_range(0, (n > 4 ? 4 : n) - 1)
                                     : $urandom_range(0, n - 5);
      end
      run_job(n, -1);
      hang_pass = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
